// File: rtl/module_execute_stage.sv
// RV32I execute stage: ID/EX pipeline register followed by forwarding muxes,
// ALU, branch/JAL resolution and misprediction detection.
module module_execute_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] pc_i,
    input  logic [WIDTH-1:0] rd1_i,
    input  logic [WIDTH-1:0] rd2_i,
    input  logic [WIDTH-1:0] imm_ext_i,
    input  logic [4:0]       rd_i,
    input  logic [2:0]       alu_control_i,
    input  logic             alu_src_i,
    input  logic [2:0]       funct3_i,
    input  logic             reg_write_i,
    input  logic             mem_write_i,
    input  logic             branch_i,
    input  logic             jump_i,
    input  logic [1:0]       result_src_i,
    input  logic             predicted_taken_i,
    input  logic [1:0]       forward_a_i,
    input  logic [1:0]       forward_b_i,
    input  logic [WIDTH-1:0] alu_result_m_i,
    input  logic [WIDTH-1:0] result_w_i,
    output logic [WIDTH-1:0] alu_result_o,
    output logic [WIDTH-1:0] write_data_o,
    output logic [4:0]       rd_o,
    output logic             reg_write_o,
    output logic             mem_write_o,
    output logic [1:0]       result_src_o,
    output logic [WIDTH-1:0] pc_plus4_o,
    output logic             taken_o,
    output logic             mispredict_o,
    output logic [WIDTH-1:0] redirect_pc_o
);

    logic             valid_q;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] rd1_q;
    logic [WIDTH-1:0] rd2_q;
    logic [WIDTH-1:0] imm_q;
    logic [4:0]       rd_q;
    logic [2:0]       alu_control_q;
    logic             alu_src_q;
    logic [2:0]       funct3_q;
    logic             reg_write_q;
    logic             mem_write_q;
    logic             branch_q;
    logic             jump_q;
    logic [1:0]       result_src_q;
    logic             predicted_taken_q;

    // A flush only has to kill the side-effecting controls; data fields are left as-is.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q           <= 1'b0;
            pc_q              <= '0;
            rd1_q             <= '0;
            rd2_q             <= '0;
            imm_q             <= '0;
            rd_q              <= '0;
            alu_control_q     <= '0;
            alu_src_q         <= 1'b0;
            funct3_q          <= '0;
            reg_write_q       <= 1'b0;
            mem_write_q       <= 1'b0;
            branch_q          <= 1'b0;
            jump_q            <= 1'b0;
            result_src_q      <= '0;
            predicted_taken_q <= 1'b0;
        end else if (flush_i) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            mem_write_q <= 1'b0;
            branch_q    <= 1'b0;
            jump_q      <= 1'b0;
        end else if (!stall_i) begin
            valid_q           <= valid_i;
            pc_q              <= pc_i;
            rd1_q             <= rd1_i;
            rd2_q             <= rd2_i;
            imm_q             <= imm_ext_i;
            rd_q              <= rd_i;
            alu_control_q     <= alu_control_i;
            alu_src_q         <= alu_src_i;
            funct3_q          <= funct3_i;
            reg_write_q       <= reg_write_i;
            mem_write_q       <= mem_write_i;
            branch_q          <= branch_i;
            jump_q            <= jump_i;
            result_src_q      <= result_src_i;
            predicted_taken_q <= predicted_taken_i;
        end
    end

    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] fwd_b;
    logic [WIDTH-1:0] src_b;
    logic [4:0]       shamt;
    logic [WIDTH-1:0] alu_result;
    logic             cond;
    logic             taken;

    always_comb begin
        src_a = rd1_q;
        case (forward_a_i)
            2'b01:   src_a = result_w_i;
            2'b10:   src_a = alu_result_m_i;
            default: src_a = rd1_q;
        endcase
    end

    always_comb begin
        fwd_b = rd2_q;
        case (forward_b_i)
            2'b01:   fwd_b = result_w_i;
            2'b10:   fwd_b = alu_result_m_i;
            default: fwd_b = rd2_q;
        endcase
    end

    assign src_b = alu_src_q ? imm_q : fwd_b;
    assign shamt = src_b[4:0];

    always_comb begin
        alu_result = '0;
        case (alu_control_q)
            3'b000:  alu_result = src_a + src_b;
            3'b001:  alu_result = src_a - src_b;
            3'b010:  alu_result = src_a & src_b;
            3'b011:  alu_result = src_a | src_b;
            3'b100:  alu_result = src_a ^ src_b;
            3'b101:  alu_result = {{(WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            3'b110:  alu_result = src_a << shamt;
            default: alu_result = src_a >> shamt;
        endcase
    end

    // Branches always compare against the register operand, never the immediate.
    always_comb begin
        cond = 1'b0;
        case (funct3_q)
            3'b000:  cond = (src_a == fwd_b);
            3'b001:  cond = (src_a != fwd_b);
            3'b100:  cond = ($signed(src_a) < $signed(fwd_b));
            3'b101:  cond = ($signed(src_a) >= $signed(fwd_b));
            3'b110:  cond = (src_a < fwd_b);
            3'b111:  cond = (src_a >= fwd_b);
            default: cond = 1'b0;
        endcase
    end

    assign taken = valid_q & (jump_q | (branch_q & cond));

    assign alu_result_o  = alu_result;
    assign write_data_o  = fwd_b;
    assign rd_o          = rd_q;
    assign reg_write_o   = valid_q & reg_write_q;
    assign mem_write_o   = valid_q & mem_write_q;
    assign result_src_o  = result_src_q;
    assign pc_plus4_o    = pc_q + WIDTH'(4);
    assign taken_o       = taken;
    assign mispredict_o  = valid_q & (branch_q | jump_q) & (taken != predicted_taken_q);
    assign redirect_pc_o = taken ? (pc_q + imm_q) : (pc_q + WIDTH'(4));

endmodule

// File: tb/tb_module_execute_stage.sv
// Scoreboard bench for module_execute_stage: driver pushes expected EX outputs,
// a negedge monitor pops and compares against the DUT.
module tb_module_execute_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stall_i, flush_i, valid_i;
    logic [31:0] pc_i, rd1_i, rd2_i, imm_ext_i;
    logic [4:0]  rd_i;
    logic [2:0]  alu_control_i, funct3_i;
    logic        alu_src_i, reg_write_i, mem_write_i, branch_i, jump_i;
    logic [1:0]  result_src_i;
    logic        predicted_taken_i;
    logic [1:0]  forward_a_i, forward_b_i;
    logic [31:0] alu_result_m_i, result_w_i;
    logic [31:0] alu_result_o, write_data_o, pc_plus4_o, redirect_pc_o;
    logic [4:0]  rd_o;
    logic        reg_write_o, mem_write_o, taken_o, mispredict_o;
    logic [1:0]  result_src_o;

    always #5 clk_i = ~clk_i;

    module_execute_stage #(.WIDTH(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
        .valid_i(valid_i), .pc_i(pc_i), .rd1_i(rd1_i), .rd2_i(rd2_i),
        .imm_ext_i(imm_ext_i), .rd_i(rd_i), .alu_control_i(alu_control_i),
        .alu_src_i(alu_src_i), .funct3_i(funct3_i), .reg_write_i(reg_write_i),
        .mem_write_i(mem_write_i), .branch_i(branch_i), .jump_i(jump_i),
        .result_src_i(result_src_i), .predicted_taken_i(predicted_taken_i),
        .forward_a_i(forward_a_i), .forward_b_i(forward_b_i),
        .alu_result_m_i(alu_result_m_i), .result_w_i(result_w_i),
        .alu_result_o(alu_result_o), .write_data_o(write_data_o), .rd_o(rd_o),
        .reg_write_o(reg_write_o), .mem_write_o(mem_write_o),
        .result_src_o(result_src_o), .pc_plus4_o(pc_plus4_o), .taken_o(taken_o),
        .mispredict_o(mispredict_o), .redirect_pc_o(redirect_pc_o)
    );

    typedef struct packed {
        logic        valid;
        logic [31:0] pc, rd1, rd2, imm;
        logic [4:0]  rd;
        logic [2:0]  aluc;
        logic        alu_src;
        logic [2:0]  f3;
        logic        rw, mw, br, jp;
        logic [1:0]  rs;
        logic        pt;
    } id_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] alu, wd, pc4, redir;
        logic [4:0]  rd;
        logic [1:0]  rs;
        logic        rw, mw, taken, misp;
    } exp_t;

    exp_t q[$];
    id_t  ex_m;
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input id_t s, input logic [1:0] fa, input logic [1:0] fb,
                                   input logic [31:0] m, input logic [31:0] w);
        exp_t        e;
        logic [31:0] a, bd, b;
        logic        c;
        a  = (fa == 2'b01) ? w : (fa == 2'b10) ? m : s.rd1;
        bd = (fb == 2'b01) ? w : (fb == 2'b10) ? m : s.rd2;
        b  = s.alu_src ? s.imm : bd;
        case (s.aluc)
            3'd0: e.alu = a + b;
            3'd1: e.alu = a - b;
            3'd2: e.alu = a & b;
            3'd3: e.alu = a | b;
            3'd4: e.alu = a ^ b;
            3'd5: e.alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd6: e.alu = a << (b % 32);
            default: e.alu = a >> (b % 32);
        endcase
        case (s.f3)
            3'd0: c = (a == bd);
            3'd1: c = (a != bd);
            3'd4: c = ($signed(a) < $signed(bd));
            3'd5: c = !($signed(a) < $signed(bd));
            3'd6: c = (a < bd);
            3'd7: c = !(a < bd);
            default: c = 1'b0;
        endcase
        e.valid = s.valid;
        e.taken = s.valid && (s.jp || (s.br && c));
        e.misp  = s.valid && (s.br || s.jp) && (e.taken != s.pt);
        e.wd    = bd;
        e.pc4   = s.pc + 32'd4;
        e.redir = e.taken ? s.pc + s.imm : s.pc + 32'd4;
        e.rd    = s.rd;
        e.rs    = s.rs;
        e.rw    = s.valid && s.rw;
        e.mw    = s.valid && s.mw;
        return e;
    endfunction

    function automatic id_t rand_id();
        id_t d;
        int  kind;
        d.valid   = ($urandom_range(0, 7) != 0);
        d.pc      = $urandom & 32'hFFFF_FFFC;
        d.rd1     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
        d.rd2     = ($urandom_range(0, 3) == 0) ? d.rd1 : $urandom;
        d.imm     = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 63)) : $urandom;
        d.rd      = 5'($urandom);
        d.aluc    = 3'($urandom);
        d.alu_src = 1'($urandom);
        d.f3      = 3'($urandom);
        d.rw      = 1'($urandom);
        d.mw      = 1'($urandom);
        d.rs      = 2'($urandom);
        d.pt      = 1'($urandom);
        kind      = $urandom_range(0, 3);
        d.br      = (kind == 0);
        d.jp      = (kind == 1);
        return d;
    endfunction

    task automatic cycle(input id_t d, input logic st, input logic fl,
                         input logic [1:0] fa, input logic [1:0] fb,
                         input logic [31:0] m, input logic [31:0] w);
        @(negedge clk_i);
        valid_i = d.valid; pc_i = d.pc; rd1_i = d.rd1; rd2_i = d.rd2; imm_ext_i = d.imm;
        rd_i = d.rd; alu_control_i = d.aluc; alu_src_i = d.alu_src; funct3_i = d.f3;
        reg_write_i = d.rw; mem_write_i = d.mw; branch_i = d.br; jump_i = d.jp;
        result_src_i = d.rs; predicted_taken_i = d.pt;
        stall_i = st; flush_i = fl;
        @(posedge clk_i);
        if (fl) begin
            ex_m.valid = 1'b0; ex_m.rw = 1'b0; ex_m.mw = 1'b0; ex_m.br = 1'b0; ex_m.jp = 1'b0;
        end else if (!st) begin
            ex_m = d;
        end
        #1;
        forward_a_i = fa; forward_b_i = fb; alu_result_m_i = m; result_w_i = w;
        q.push_back(model(ex_m, fa, fb, m, w));
    endtask

    always @(negedge clk_i) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            check("reg_write", reg_write_o, mon_e.rw);
            check("mem_write", mem_write_o, mon_e.mw);
            check("taken", taken_o, mon_e.taken);
            check("mispredict", mispredict_o, mon_e.misp);
            if (mon_e.valid) begin
                check("alu_result", alu_result_o, mon_e.alu);
                check("write_data", write_data_o, mon_e.wd);
                check("rd", rd_o, mon_e.rd);
                check("result_src", result_src_o, mon_e.rs);
                check("pc_plus4", pc_plus4_o, mon_e.pc4);
                check("redirect_pc", redirect_pc_o, mon_e.redir);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        id_t d, d1;
        rst_i = 1'b1; stall_i = 0; flush_i = 0; valid_i = 0; pc_i = 0; rd1_i = 0; rd2_i = 0;
        imm_ext_i = 0; rd_i = 0; alu_control_i = 0; alu_src_i = 0; funct3_i = 0;
        reg_write_i = 0; mem_write_i = 0; branch_i = 0; jump_i = 0; result_src_i = 0;
        predicted_taken_i = 0; forward_a_i = 0; forward_b_i = 0;
        alu_result_m_i = 0; result_w_i = 0;
        ex_m = '0;
        #2;
        check("rst_alu_result", alu_result_o, 32'd0);
        check("rst_write_data", write_data_o, 32'd0);
        check("rst_rd", rd_o, 32'd0);
        check("rst_result_src", result_src_o, 32'd0);
        check("rst_reg_write", reg_write_o, 32'd0);
        check("rst_mem_write", mem_write_o, 32'd0);
        check("rst_pc_plus4", pc_plus4_o, 32'd4);
        check("rst_taken", taken_o, 32'd0);
        check("rst_mispredict", mispredict_o, 32'd0);
        check("rst_redirect_pc", redirect_pc_o, 32'd4);
        @(negedge clk_i);
        rst_i = 1'b0;

        // asynchronous reset in the middle of an add
        d = '0; d.valid = 1; d.rd1 = 5; d.rd2 = 7; d.rw = 1; d.pc = 32'h80;
        cycle(d, 0, 0, 2'b00, 2'b00, 0, 0);
        @(negedge clk_i);
        #1;
        rst_i = 1'b1;
        #1;
        check("async_rst_alu_result", alu_result_o, 32'd0);
        check("async_rst_reg_write", reg_write_o, 32'd0);
        check("async_rst_redirect_pc", redirect_pc_o, 32'd4);
        ex_m = '0;
        @(negedge clk_i);
        rst_i = 1'b0;

        for (int i = 0; i < 8; i++) begin
            d = '0; d.valid = 1; d.pc = 32'h200; d.rd1 = 32'hFFFF_FFF0; d.imm = 32'h4;
            d.alu_src = 1; d.aluc = 3'(i); d.rw = 1; d.rd = 5'(i + 1);
            cycle(d, 0, 0, 2'b00, 2'b00, 0, 0);
        end

        d = '0; d.valid = 1; d.rd1 = 1; d.imm = 3; d.alu_src = 1; d.rw = 1; d.pc = 32'h300;
        cycle(d, 0, 0, 2'b10, 2'b00, 32'h10, 32'h0);
        cycle(d, 0, 0, 2'b01, 2'b00, 32'h0, 32'h20);

        d = '0; d.valid = 1; d.pc = 32'h100; d.imm = 32'h40; d.rd1 = 9; d.rd2 = 9;
        d.br = 1; d.f3 = 3'b000; d.pt = 0; d.aluc = 3'd1;
        cycle(d, 0, 0, 2'b00, 2'b00, 0, 0);
        d.rd1 = 1; d.rd2 = 32'hFFFF_FFFF; d.f3 = 3'b110; d.pt = 1;
        cycle(d, 0, 0, 2'b00, 2'b00, 0, 0);

        d = '0; d.valid = 1; d.pc = 32'h400; d.rd1 = 32'h1234; d.rd2 = 32'h55; d.rw = 1;
        d.mw = 1; d.br = 1; d.f3 = 3'b001; d.pt = 0; d.imm = 32'h20; d.rd = 5'd7; d.rs = 2'd2;
        cycle(d, 0, 0, 2'b00, 2'b00, 0, 0);
        d1 = rand_id();
        cycle(d1, 1, 0, 2'b00, 2'b00, 0, 0);
        cycle(d1, 1, 0, 2'b00, 2'b00, 0, 0);
        cycle(d1, 1, 1, 2'b00, 2'b00, 0, 0);

        d = '0; d.valid = 1; d.pc = 32'h500; d.rd1 = 32'hF0F0; d.rd2 = 32'h0FF0; d.aluc = 3'd4;
        d.pt = 1; d.rw = 1; d.imm = 32'h80;
        cycle(d, 0, 0, 2'b00, 2'b00, 0, 0);

        for (int i = 0; i < 400; i++) begin
            d = rand_id();
            cycle(d, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                  2'($urandom), 2'($urandom), $urandom, $urandom);
        end

        repeat (2) @(negedge clk_i);
        #1;
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/module_execute_stage.md
Name: module_execute_stage

Overview:
- Execute stage of the RV32I pipeline: the ID/EX pipeline register plus the EX datapath that consumes the 3-bit ALU control word from the ALU decoder.
- Latches decode-stage operands and controls, applies forwarding muxes, computes the ALU result, and resolves branches and JAL.
- Flags branch-prediction mispredictions to the fetch/predictor logic and drives the EX/MEM-side outputs combinationally from the registered state.

Parameters:
- WIDTH, 32, datapath width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- stall_i  in  1  hold ID/EX register contents.
- flush_i  in  1  load a bubble into ID/EX.
- valid_i  in  1  decode-stage instruction valid.
- pc_i  in  WIDTH  instruction PC.
- rd1_i  in  WIDTH  register-file port 1 data.
- rd2_i  in  WIDTH  register-file port 2 data.
- imm_ext_i  in  WIDTH  sign-extended immediate.
- rd_i  in  5  destination register.
- alu_control_i  in  3  ALU control from the ALU decoder.
- alu_src_i  in  1  1 selects immediate as operand B.
- funct3_i  in  3  branch condition select.
- reg_write_i, mem_write_i, branch_i, jump_i  in  1 each  decode controls.
- result_src_i  in  2  writeback source select.
- predicted_taken_i  in  1  predictor decision made at fetch.
- forward_a_i, forward_b_i  in  2 each  00 = register, 01 = result_w_i, 10 = alu_result_m_i, 11 = register.
- alu_result_m_i  in  WIDTH  MEM-stage forward value.
- result_w_i  in  WIDTH  WB-stage forward value.
- alu_result_o  out  WIDTH  ALU result.
- write_data_o  out  WIDTH  forwarded operand B before the immediate mux (store data).
- rd_o  out  5  registered rd.
- reg_write_o, mem_write_o  out  1 each  registered controls, gated by valid.
- result_src_o  out  2  registered writeback select.
- pc_plus4_o  out  WIDTH  registered pc + 4.
- taken_o  out  1  actual control-flow outcome.
- mispredict_o  out  1  actual outcome differs from prediction.
- redirect_pc_o  out  WIDTH  correct next PC.

Behaviour:
- ID/EX register update priority: rst_i > flush_i > stall_i > load.
- rst_i (asynchronous) clears every registered field to 0.
- flush_i clears valid, reg_write, mem_write, branch and jump. Data fields are don't-care; bench compares them only when valid = 1.
- stall_i holds all fields.
- flush_i together with stall_i: flush wins.
- Reset values of outputs: alu_result_o = 0, write_data_o = 0, rd_o = 0, result_src_o = 0, reg_write_o = 0, mem_write_o = 0, pc_plus4_o = 4, taken_o = 0, mispredict_o = 0, redirect_pc_o = 4.
- Latency: EX outputs are valid in the cycle after the ID inputs are captured; combinational from register plus forwarding inputs.
- Operand muxes:
  - srcA = forwarded rd1.
  - write_data = forwarded rd2.
  - srcB = alu_src ? imm : write_data.
- ALU encoding (WIDTH-bit, wraps modulo 2^WIDTH):
  - 000 add; 001 sub.
  - 010 and; 011 or; 100 xor.
  - 101 slt, signed, result 0 or 1.
  - 110 sll by srcB[4:0]; 111 srl (logical) by srcB[4:0].
- Branch compare on srcA vs forwarded rd2, selected by funct3:
  - 000 eq; 001 ne; 100 signed lt; 101 signed ge; 110 unsigned lt; 111 unsigned ge.
  - 010/011: condition false.
- taken_o = valid & (jump | (branch & cond)).
- mispredict_o = valid & (branch | jump) & (taken_o != predicted_taken).
- redirect_pc_o = taken_o ? pc + imm : pc + 4, wrapping at 2^WIDTH.
- reg_write_o and mem_write_o are forced to 0 when valid = 0.
- Non-branch/non-jump instructions never assert mispredict_o, regardless of predicted_taken.

Test Plan:
- Reset mid-operation: load add with rd1 = 5, rd2 = 7, then assert rst_i asynchronously -> alu_result_o = 0, reg_write_o = 0, redirect_pc_o = 4 immediately, without waiting for a clock edge.
- Sweep all 8 alu_control codes with srcA = 0xFFFF_FFF0, srcB = 0x0000_0004 -> add 0xFFFF_FFF4, sub 0xFFFF_FFEC, and 0x0, or 0xFFFF_FFF4, xor 0xFFFF_FFF4, slt 1, sll 0xFFFF_FF00, srl 0x0FFF_FFFF.
- Forwarding: rd1 = 1, alu_result_m_i = 0x10, forward_a = 10, add with imm = 3 -> 0x13; forward_a = 01 with result_w_i = 0x20 -> 0x23.
- Branch mispredict: beq, pc = 0x100, imm = 0x40, srcA = srcB = 9, predicted_taken = 0 -> taken_o = 1, mispredict_o = 1, redirect_pc_o = 0x140. bltu with 1 vs 0xFFFF_FFFF, predicted 1 -> taken_o = 1, mispredict_o = 0.
- Stall/flush: stall_i held 2 cycles -> outputs unchanged; flush_i and stall_i together -> next cycle reg_write_o = 0, mem_write_o = 0, mispredict_o = 0.
- Non-branch: xor with predicted_taken = 1 -> mispredict_o = 0, redirect_pc_o = pc + 4.
